// File: rtl/fire_expand3_pkg.sv
// Shared types and default geometry for the fire4/fire5 expand-3x3 scheduler.
// Default config: 32x32 output map, 32 input channels, 3x3 kernel.
package fire_expand3_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FINISH
   } state_t;

   localparam int WOUT_DEF    = 32;
   localparam int CHIN_DEF    = 32;
   localparam int KDIM_DEF    = 3;
   localparam int CLR_LAT_DEF = 3;
   localparam int K           = KDIM_DEF * KDIM_DEF * CHIN_DEF;
   localparam int WIN         = WOUT_DEF * WOUT_DEF;

   function automatic int taps(input int kdim, input int chin);
      return kdim * kdim * chin;
   endfunction

endpackage

// File: rtl/fire_expand3_scheduler_pulse_delay.sv
// Fixed-latency pulse delay: q follows d exactly DEPTH cycles later.
// Used to line up the window-end clear with the ROM/ifm/kernel pipeline.
module pulse_delay
   import fire_expand3_pkg::*;
#(
   parameter int DEPTH = CLR_LAT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] sr;

   // shift the event down the pipe; reset drops anything in flight
   always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else     sr <= (sr << 1) | DEPTH'(d);
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/fire_expand3_scheduler.sv
// Grants the shared expand-3x3 MAC array to fire4 or fire5, walks the weight
// ROM per window, emits clear/sample strobes and holds finish until RAM ack.
module fire_expand3_scheduler
   import fire_expand3_pkg::*;
#(
   parameter int WOUT    = WOUT_DEF,
   parameter int CHIN    = CHIN_DEF,
   parameter int KDIM    = KDIM_DEF,
   parameter int CLR_LAT = CLR_LAT_DEF,
   parameter int ADDR_W  = $clog2(KDIM * KDIM * CHIN),
   parameter int PIX_W   = $clog2(WOUT * WOUT) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req4_i,
   input  logic              req5_i,
   input  logic              ram_feedback_4,
   input  logic              ram_feedback_5,
   output logic              sel5_o,
   output logic              mac_en_o,
   output logic              ifm_rd_o,
   output logic [ADDR_W-1:0] weight_rom_addr_o,
   output logic              mac_clr_o,
   output logic              ofm_sample_o,
   output logic [PIX_W-1:0]  pix_idx_o,
   output logic              busy_o,
   output logic              fire4_finish_o,
   output logic              fire5_finish_o
);

   localparam int TAPS = taps(KDIM, CHIN);
   localparam int NWIN = WOUT * WOUT;
   localparam int DW   = $clog2(CLR_LAT + 2);

   state_t            state, state_n;
   logic              sel5, done4, done5;
   logic              grant4, grant5;
   logic              wrap, last_win, fb;
   logic              clr, sample;
   logic [ADDR_W-1:0] addr;
   logic [PIX_W-1:0]  win_cnt, pix;
   logic [DW-1:0]     drn;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // next state, grant arbitration and status outputs
   always_comb begin
      state_n  = state;
      grant4   = 1'b0;
      grant5   = 1'b0;
      wrap     = (state == RUN) && (addr == ADDR_W'(TAPS - 1));
      last_win = (win_cnt == PIX_W'(NWIN - 1));
      fb       = sel5 ? ram_feedback_5 : ram_feedback_4;
      unique case (state)
         IDLE: begin
            if (req4_i && !done4) begin
               grant4  = 1'b1;
               state_n = RUN;
            end else if (req5_i && !done5) begin
               grant5  = 1'b1;
               state_n = RUN;
            end
         end
         RUN:     if (wrap && last_win)     state_n = DRAIN;
         DRAIN:   if (drn == DW'(CLR_LAT))  state_n = FINISH;
         FINISH:  if (fb)                   state_n = IDLE;
         default:                           state_n = IDLE;
      endcase
      mac_en_o       = (state == RUN) || (state == DRAIN);
      ifm_rd_o       = (state == RUN);
      busy_o         = (state != IDLE);
      fire4_finish_o = (state == FINISH) && !sel5;
      fire5_finish_o = (state == FINISH) && sel5;
   end

   // address walk, window/pixel counters, drain timer and sticky done flags
   always_ff @(posedge clk) begin
      if (rst) begin
         sel5    <= 1'b0;
         done4   <= 1'b0;
         done5   <= 1'b0;
         addr    <= '0;
         win_cnt <= '0;
         pix     <= '0;
         drn     <= '0;
         sample  <= 1'b0;
      end else begin
         sample <= clr;
         if (grant4 || grant5) begin
            sel5    <= grant5;
            addr    <= '0;
            win_cnt <= '0;
            pix     <= '0;
         end else begin
            if (state == RUN) addr <= wrap ? '0 : addr + 1'b1;
            if (wrap)         win_cnt <= win_cnt + 1'b1;
            if (sample)       pix <= pix + 1'b1;
         end
         drn <= (state == DRAIN) ? drn + 1'b1 : '0;
         if (state == FINISH) begin
            if (sel5) done5 <= 1'b1;
            else      done4 <= 1'b1;
         end
      end
   end

   pulse_delay #(
      .DEPTH (CLR_LAT)
   ) u_clr_dly (
      .clk (clk),
      .rst (rst),
      .d   (wrap),
      .q   (clr)
   );

   assign sel5_o            = sel5;
   assign weight_rom_addr_o = addr;
   assign mac_clr_o         = clr;
   assign ofm_sample_o      = sample;
   assign pix_idx_o         = pix;

endmodule

// File: tb/tb_fire_expand3_scheduler.sv
// Bench for fire_expand3_scheduler: small config vectors, corner sequences,
// random traffic against a timeline model, and a larger-config run.
module tb_fire_expand3_scheduler;

   localparam int CL = 3;
   localparam int K  = 9;
   localparam int WN = 4;
   localparam int L  = K * WN;

   localparam int B_CL = 2;
   localparam int B_K  = 144;
   localparam int B_WN = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, req4, req5, fb4, fb5;
   logic       sel5, mac_en, ifm_rd, clr, smp, busy, f4, f5;
   logic [3:0] addr;
   logic [2:0] pix;

   logic       b_rst, b_req4, b_req5, b_fb4, b_fb5;
   logic       b_sel5, b_mac_en, b_ifm_rd, b_clr, b_smp, b_busy, b_f4, b_f5;
   logic [7:0] b_addr;
   logic [4:0] b_pix;

   fire_expand3_scheduler #(
      .WOUT(2), .CHIN(1), .KDIM(3), .CLR_LAT(CL)
   ) dut (
      .clk(clk), .rst(rst), .req4_i(req4), .req5_i(req5),
      .ram_feedback_4(fb4), .ram_feedback_5(fb5),
      .sel5_o(sel5), .mac_en_o(mac_en), .ifm_rd_o(ifm_rd),
      .weight_rom_addr_o(addr), .mac_clr_o(clr), .ofm_sample_o(smp),
      .pix_idx_o(pix), .busy_o(busy),
      .fire4_finish_o(f4), .fire5_finish_o(f5)
   );

   fire_expand3_scheduler #(
      .WOUT(4), .CHIN(16), .KDIM(3), .CLR_LAT(B_CL)
   ) dut_b (
      .clk(clk), .rst(b_rst), .req4_i(b_req4), .req5_i(b_req5),
      .ram_feedback_4(b_fb4), .ram_feedback_5(b_fb5),
      .sel5_o(b_sel5), .mac_en_o(b_mac_en), .ifm_rd_o(b_ifm_rd),
      .weight_rom_addr_o(b_addr), .mac_clr_o(b_clr), .ofm_sample_o(b_smp),
      .pix_idx_o(b_pix), .busy_o(b_busy),
      .fire4_finish_o(b_f4), .fire5_finish_o(b_f5)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // timeline model: layer granted (0 none), cycles since grant
   int m_layer = 0;
   int m_r = 0;
   bit m_sel = 0, m_d4 = 0, m_d5 = 0;
   int m_idle_pix = 0;
   int smp_seen = 0;

   typedef struct {
      bit r, q4, q5, a4, a5;
      int n;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[18];

   function automatic logic [15:0] pk(
      bit b, bit s, bit e, bit i, int a, bit c, bit m, int p, bit x4, bit x5);
      return {b, s, e, i, 4'(a), c, m, 3'(p), x4, x5};
   endfunction

   function automatic logic [15:0] act_vec();
      return {busy, sel5, mac_en, ifm_rd, addr, clr, smp, pix, f4, f5};
   endfunction

   function automatic logic [15:0] exp_vec();
      bit act, e, i, c, m, fin;
      int a, p, x, t;
      act = (m_layer != 0);
      e = act && (m_r < L + CL + 1);
      i = act && (m_r < L);
      a = i ? (m_r % K) : 0;
      t = m_r - CL;
      c = act && t >= 0 && t < L && (t % K) == K - 1;
      x = m_r - CL - 1;
      m = act && x >= 0 && x < L && (x % K) == K - 1;
      fin = act && (m_r >= L + CL + 1);
      if (!act) p = m_idle_pix;
      else begin
         p = (x >= K) ? x / K : 0;
         if (p > WN) p = WN;
      end
      return pk(act, m_sel, e, i, a, c, m, p,
                fin && m_layer == 4, fin && m_layer == 5);
   endfunction

   task automatic model_step();
      if (rst) begin
         m_layer = 0; m_r = 0; m_sel = 0;
         m_d4 = 0; m_d5 = 0; m_idle_pix = 0;
      end else if (m_layer == 0) begin
         if (req4 && !m_d4) begin
            m_layer = 4; m_r = 0; m_sel = 0;
         end else if (req5 && !m_d5) begin
            m_layer = 5; m_r = 0; m_sel = 1;
         end
      end else if (m_r >= L + CL + 1 &&
                   ((m_layer == 4 && fb4) || (m_layer == 5 && fb5))) begin
         if (m_layer == 4) m_d4 = 1;
         else              m_d5 = 1;
         m_layer = 0;
         m_idle_pix = WN;
      end else begin
         m_r++;
      end
   endtask

   task automatic check(input string name, input logic [15:0] got,
                        input logic [15:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("model", act_vec(), exp_vec());
      if (smp) smp_seen++;
   endtask

   task automatic set_in(bit r, bit q4, bit q5, bit a4, bit a5);
      rst = r; req4 = q4; req5 = q5; fb4 = a4; fb5 = a5;
   endtask

   function automatic vec_t mk(bit r, bit q4, bit q5, bit a4, bit a5,
                               int n, logic [15:0] e);
      vec_t v;
      v.r = r; v.q4 = q4; v.q5 = q5; v.a4 = a4; v.a5 = a5;
      v.n = n; v.exp = e;
      return v;
   endfunction

   initial begin
      int last_t, cnt, gap_bad, fin_gap;
      bit got_fin;

      set_in(1, 0, 0, 0, 0);
      b_rst = 1; b_req4 = 0; b_req5 = 0; b_fb4 = 0; b_fb5 = 0;

      //          rst q4 q5 a4 a5  n   busy sel en ifm addr clr smp pix f4 f5
      tbl[0]  = mk(1, 0, 0, 0, 0, 2, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl[1]  = mk(0, 1, 0, 0, 0, 1, pk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      tbl[2]  = mk(0, 1, 0, 1, 0, 5, pk(1, 0, 1, 1, 5, 0, 0, 0, 0, 0));
      tbl[3]  = mk(0, 0, 0, 0, 0, 30, pk(1, 0, 1, 1, 8, 0, 0, 3, 0, 0));
      tbl[4]  = mk(0, 0, 0, 0, 0, 1, pk(1, 0, 1, 0, 0, 0, 0, 3, 0, 0));
      tbl[5]  = mk(0, 0, 0, 0, 0, 3, pk(1, 0, 1, 0, 0, 0, 1, 3, 0, 0));
      tbl[6]  = mk(0, 0, 0, 0, 0, 1, pk(1, 0, 0, 0, 0, 0, 0, 4, 1, 0));
      tbl[7]  = mk(0, 0, 0, 0, 1, 3, pk(1, 0, 0, 0, 0, 0, 0, 4, 1, 0));
      tbl[8]  = mk(0, 0, 1, 1, 0, 1, pk(0, 0, 0, 0, 0, 0, 0, 4, 0, 0));
      tbl[9]  = mk(0, 1, 1, 0, 0, 1, pk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
      tbl[10] = mk(0, 1, 1, 0, 0, 40, pk(1, 1, 0, 0, 0, 0, 0, 4, 0, 1));
      tbl[11] = mk(0, 0, 0, 0, 1, 1, pk(0, 1, 0, 0, 0, 0, 0, 4, 0, 0));
      tbl[12] = mk(0, 1, 1, 0, 0, 3, pk(0, 1, 0, 0, 0, 0, 0, 4, 0, 0));
      tbl[13] = mk(1, 0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl[14] = mk(0, 1, 0, 0, 0, 6, pk(1, 0, 1, 1, 5, 0, 0, 0, 0, 0));
      tbl[15] = mk(1, 0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl[16] = mk(0, 0, 0, 0, 0, 3, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl[17] = mk(0, 1, 0, 0, 0, 1, pk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0));

      for (int v = 0; v < 18; v++) begin
         set_in(tbl[v].r, tbl[v].q4, tbl[v].q5, tbl[v].a4, tbl[v].a5);
         repeat (tbl[v].n) tick();
         check($sformatf("vec%0d", v), act_vec(), tbl[v].exp);
      end

      // both layers request together: fire4 first, then fire5
      set_in(1, 0, 0, 0, 0);
      tick();
      set_in(0, 1, 1, 0, 0);
      smp_seen = 0;
      for (int c = 0; c < 200 && !f4; c++) tick();
      check("both_f4_finish", {31'd0, f4}, 32'd1);
      check("both_f4_samples", smp_seen, WN);
      fb4 = 1;
      tick();
      fb4 = 0;
      tick();
      check("both_f5_grant", {busy, sel5}, 2'b11);
      smp_seen = 0;
      for (int c = 0; c < 200 && !f5; c++) tick();
      check("both_f5_finish", {f4, f5}, 2'b01);
      check("both_f5_samples", smp_seen, WN);
      fb5 = 1;
      tick();
      fb5 = 0;

      // random traffic against the model
      for (int c = 0; c < 4000; c++) begin
         rst  = ($urandom_range(0, 299) == 0);
         req4 = ($urandom_range(0, 3) != 0);
         req5 = ($urandom_range(0, 2) != 0);
         fb4  = ($urandom_range(0, 7) == 0);
         fb5  = ($urandom_range(0, 7) == 0);
         tick();
      end
      set_in(0, 0, 0, 0, 0);

      // larger config: sample count, spacing and finish ordering
      @(negedge clk);
      b_rst = 0;
      b_req4 = 1;
      cnt = 0; last_t = -1; gap_bad = 0; got_fin = 0; fin_gap = 0;
      for (int c = 0; c < 5000; c++) begin
         @(posedge clk);
         #1;
         if (b_smp) begin
            if (last_t >= 0 && c - last_t != B_K) gap_bad++;
            last_t = c;
            cnt++;
         end
         if (b_f4) begin
            got_fin = 1;
            fin_gap = c - last_t;
            break;
         end
      end
      check("big_finish", {31'd0, got_fin}, 32'd1);
      check("big_samples", cnt, B_WN);
      check("big_spacing", gap_bad, 0);
      check("big_fin_after_smp", fin_gap, 1);
      check("big_pix_end", {27'd0, b_pix}, B_WN);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
